vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter NPROD, default 4, number of selectable products.
REQ-002 SHALL have parameter CW, default 8, credit width in bits (units of 1 cent).
REQ-003 SHALL have parameter MAX_CREDIT, default 100, maximum accepted credit.
REQ-004 SHALL have parameter PRICES, default {8'd50,8'd40,8'd35,8'd30}, NPROD*CW bits, product i at bits [i*CW +: CW]; every price a nonzero multiple of 5.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 coin_valid  in  1  coin present this cycle.
REQ-008 coin  in  2  01=5, 10=10, 11=25, 00=invalid.
REQ-009 sel_valid  in  1  product selection strobe.
REQ-010 sel  in  clog2(NPROD)  product index.
REQ-011 cancel  in  1  refund request.
REQ-012 credit  out  CW  current credit.
REQ-013 disp_valid / disp_id / disp_ready  out/out/in  1/clog2(NPROD)/1  dispense handshake.
REQ-014 chg_valid / chg_coin / chg_ready  out/out/in  1/2/1  change handshake, one coin per transfer, coin encoding as REQ-008.
REQ-015 reject  out  1  one-cycle pulse: coin refused.
REQ-016 insuf  out  1  one-cycle pulse: selection refused for low credit or sel >= NPROD.
REQ-017 busy  out  1  high when state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, DISPENSE, CHANGE.
REQ-019 In IDLE, priority SHALL be cancel > sel_valid > coin_valid; a coin arriving in a cycle where cancel or a successful selection is taken SHALL be rejected.
REQ-020 In IDLE, cancel with credit>0 SHALL go to CHANGE next cycle; cancel with credit=0 SHALL have no effect.
REQ-021 In IDLE, sel_valid with sel<NPROD and credit>=price SHALL subtract price, latch disp_id, and go to DISPENSE next cycle.
REQ-022 In IDLE, sel_valid otherwise SHALL pulse insuf and leave credit unchanged.
REQ-023 In IDLE, accepted coin SHALL add its value to credit next cycle if result <= MAX_CREDIT; otherwise, or for coin=00, SHALL pulse reject.
REQ-024 Any coin_valid in DISPENSE or CHANGE SHALL pulse reject; sel_valid and cancel there SHALL be ignored.
REQ-025 In DISPENSE, disp_valid SHALL stay high with stable disp_id until the cycle disp_ready=1; then next state SHALL be CHANGE if credit>0, else IDLE.
REQ-026 In CHANGE, chg_coin SHALL be the largest of 25/10/5 not exceeding credit; on chg_valid&chg_ready credit SHALL drop by that value; when credit reaches 0, SHALL return to IDLE next cycle.
REQ-027 Credit SHALL always be a multiple of 5 and never exceed MAX_CREDIT; arithmetic SHALL be unsigned CW bits without wrap.
REQ-028 Handshake outputs SHALL be registered; reject and insuf SHALL assert the cycle after the cause.

Reset
REQ-029 rst SHALL force IDLE, credit=0, all valid/pulse outputs 0, disp_id=0, chg_coin=00, at the next rising edge.
REQ-030 rst mid-DISPENSE or mid-CHANGE SHALL abort the transfer and discard remaining credit; no change is paid.

Configuration
REQ-031 Macro VEND_SALES_CNT_EN defined: SHALL add output sales_cnt, NPROD*16 bits, per-product counters incremented on each completed dispense, saturating at 16'hFFFF, cleared by rst.
REQ-032 Macro undefined: SHALL omit sales_cnt port and counter logic entirely.

Structure
REQ-033 Package vend_pkg SHALL hold state enum, coin encoding constants, and coin value constants (5/10/25).
REQ-034 Sub-module vend_change SHALL compute chg_coin and its value from credit combinationally.

Verification
REQ-035 Coins 10,10,10 then sel=3 (price 30) -> credit 30, disp_valid with disp_id=3, credit 0, return to IDLE, no chg_valid.
REQ-036 Coins 25,25 then sel=0 (price 50) with disp_ready delayed 3 cycles -> disp_valid held 4 cycles, credit 0, no change.
REQ-037 Coins 25,25,25 then sel=2 (35) -> change sequence 25,10,5 with chg_ready each cycle, then credit 0, IDLE.
REQ-038 Credit 90, coin 25 -> reject pulse, credit stays 90; sel=1 with credit 20 -> insuf pulse, credit 20.
REQ-039 Coin 25 and cancel same cycle -> coin rejected, change 25 when credit was 25; rst during CHANGE -> credit 0, chg_valid 0 next cycle.
REQ-040 With VEND_SALES_CNT_EN: two dispenses of product 1 -> sales_cnt[31:16]=2, others 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin codes and coin values.
package vend_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDispense,
        StChange
    } state_e;

    localparam logic [1:0] CoinNone = 2'b00;
    localparam logic [1:0] Coin5    = 2'b01;
    localparam logic [1:0] Coin10   = 2'b10;
    localparam logic [1:0] Coin25   = 2'b11;

    localparam logic [4:0] Val5  = 5'd5;
    localparam logic [4:0] Val10 = 5'd10;
    localparam logic [4:0] Val25 = 5'd25;

    function automatic logic [4:0] coin_value(input logic [1:0] code);
        logic [4:0] val;
        unique case (code)
            Coin5:   val = Val5;
            Coin10:  val = Val10;
            Coin25:  val = Val25;
            default: val = 5'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Dispense and change handshakes of the vending controller; master is the controller side.
interface vend_ctrl_if #(
    parameter int unsigned NPROD = 4
);
    localparam int unsigned SW = (NPROD > 1) ? $clog2(NPROD) : 1;

    logic          disp_valid;
    logic [SW-1:0] disp_id;
    logic          disp_ready;
    logic          chg_valid;
    logic [1:0]    chg_coin;
    logic          chg_ready;

    modport master (
        output disp_valid, disp_id, chg_valid, chg_coin,
        input  disp_ready, chg_ready
    );

    modport slave (
        input  disp_valid, disp_id, chg_valid, chg_coin,
        output disp_ready, chg_ready
    );

endinterface

// File: rtl/vend_change.sv
// Picks the largest coin (25/10/5) not exceeding the given credit, plus its value.
module vend_change
    import vend_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] credit_i,
    output logic [1:0]    coin_o,
    output logic [CW-1:0] value_o
);

    always_comb begin
        coin_o = CoinNone;
        if (credit_i >= CW'(Val25)) begin
            coin_o = Coin25;
        end else if (credit_i >= CW'(Val10)) begin
            coin_o = Coin10;
        end else if (credit_i >= CW'(Val5)) begin
            coin_o = Coin5;
        end
        value_o = CW'(coin_value(coin_o));
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit, product dispense and coin-by-coin change.
// Optional per-product sales counters are enabled with `define VEND_SALES_CNT_EN.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned          NPROD      = 4,
    parameter int unsigned          CW         = 8,
    parameter int unsigned          MAX_CREDIT = 100,
    parameter logic [NPROD*CW-1:0]  PRICES     = {8'd50, 8'd40, 8'd35, 8'd30},
    localparam int unsigned         SW         = (NPROD > 1) ? $clog2(NPROD) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_valid,
    input  logic [1:0]    coin,
    input  logic          sel_valid,
    input  logic [SW-1:0] sel,
    input  logic          cancel,
    output logic [CW-1:0] credit,
    vend_ctrl_if.master   hs,
    output logic          reject,
    output logic          insuf,
    output logic          busy
`ifdef VEND_SALES_CNT_EN
    ,
    output logic [NPROD*16-1:0] sales_cnt
`endif
);

    state_e        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [SW-1:0] disp_id_q, disp_id_d;
    logic          disp_valid_q, disp_valid_d;
    logic          chg_valid_q, chg_valid_d;
    logic [1:0]    chg_coin_q, chg_coin_d;
    logic [CW-1:0] chg_val_q, chg_val_d;
    logic          reject_q, reject_d;
    logic          insuf_q, insuf_d;

    logic [CW-1:0] price;
    logic [CW:0]   sum;
    logic          coin_ok;
    logic          sel_ok;
    logic          taken;
    logic [1:0]    next_coin;
    logic [CW-1:0] next_val;

`ifdef VEND_SALES_CNT_EN
    logic [NPROD*16-1:0] sales_q, sales_d;
`endif

    // Change coin is chosen from the credit that will hold once this cycle commits.
    vend_change #(
        .CW (CW)
    ) u_change (
        .credit_i (credit_d),
        .coin_o   (next_coin),
        .value_o  (next_val)
    );

    always_comb begin
        price = '0;
        for (int i = 0; i < NPROD; i++) begin
            if (sel == SW'(i)) begin
                price = PRICES[i*CW +: CW];
            end
        end
        sum     = {1'b0, credit_q} + (CW+1)'(coin_value(coin));
        coin_ok = (coin != CoinNone) && (sum <= (CW+1)'(MAX_CREDIT));
        sel_ok  = (32'(sel) < NPROD) && (credit_q >= price);
    end

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        disp_id_d = disp_id_q;
        reject_d  = 1'b0;
        insuf_d   = 1'b0;
        taken     = 1'b0;
`ifdef VEND_SALES_CNT_EN
        sales_d   = sales_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cancel && (credit_q != '0)) begin
                    state_d = StChange;
                    taken   = 1'b1;
                end else if (sel_valid) begin
                    if (sel_ok) begin
                        credit_d  = credit_q - price;
                        disp_id_d = sel;
                        state_d   = StDispense;
                        taken     = 1'b1;
                    end else begin
                        insuf_d = 1'b1;
                    end
                end
                // A coin only lands when nothing of higher priority was taken this cycle.
                if (coin_valid) begin
                    if (taken || !coin_ok) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum[CW-1:0];
                    end
                end
            end
            StDispense: begin
                reject_d = coin_valid;
                if (hs.disp_ready) begin
                    state_d = (credit_q != '0) ? StChange : StIdle;
`ifdef VEND_SALES_CNT_EN
                    for (int i = 0; i < NPROD; i++) begin
                        if ((disp_id_q == SW'(i)) && (sales_q[i*16 +: 16] != 16'hFFFF)) begin
                            sales_d[i*16 +: 16] = sales_q[i*16 +: 16] + 16'd1;
                        end
                    end
`endif
                end
            end
            StChange: begin
                reject_d = coin_valid;
                if (hs.chg_ready) begin
                    credit_d = credit_q - chg_val_q;
                    if (credit_d == '0) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        disp_valid_d = (state_d == StDispense);
        chg_valid_d  = (state_d == StChange);
        chg_coin_d   = chg_valid_d ? next_coin : CoinNone;
        chg_val_d    = chg_valid_d ? next_val : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            credit_q     <= '0;
            disp_id_q    <= '0;
            disp_valid_q <= 1'b0;
            chg_valid_q  <= 1'b0;
            chg_coin_q   <= CoinNone;
            chg_val_q    <= '0;
            reject_q     <= 1'b0;
            insuf_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            disp_id_q    <= disp_id_d;
            disp_valid_q <= disp_valid_d;
            chg_valid_q  <= chg_valid_d;
            chg_coin_q   <= chg_coin_d;
            chg_val_q    <= chg_val_d;
            reject_q     <= reject_d;
            insuf_q      <= insuf_d;
        end
    end

`ifdef VEND_SALES_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sales_q <= '0;
        end else begin
            sales_q <= sales_d;
        end
    end

    assign sales_cnt = sales_q;
`endif

    assign credit        = credit_q;
    assign hs.disp_valid = disp_valid_q;
    assign hs.disp_id    = disp_id_q;
    assign hs.chg_valid  = chg_valid_q;
    assign hs.chg_coin   = chg_coin_q;
    assign reject        = reject_q;
    assign insuf         = insuf_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: transaction-level reference model checked every cycle, plus directed
// scenarios with hand-computed expectations. Define VEND_SALES_CNT_EN to cover the sales counters.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       cancel = 1'b0;
    logic [7:0] credit;
    logic       reject;
    logic       insuf;
    logic       busy;
`ifdef VEND_SALES_CNT_EN
    logic [63:0] sales_cnt;
`endif

    vend_ctrl_if #(.NPROD(4)) hs ();

    // Prices listed high index first, so product 0 = 50, 1 = 40, 2 = 35, 3 = 30.
    vend_ctrl #(
        .NPROD      (4),
        .CW         (8),
        .MAX_CREDIT (100),
        .PRICES     ({8'd30, 8'd35, 8'd40, 8'd50})
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_valid (coin_valid),
        .coin       (coin),
        .sel_valid  (sel_valid),
        .sel        (sel),
        .cancel     (cancel),
        .credit     (credit),
        .hs         (hs.master),
        .reject     (reject),
        .insuf      (insuf),
        .busy       (busy)
`ifdef VEND_SALES_CNT_EN
        ,
        .sales_cnt  (sales_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int mp[4] = '{50, 40, 35, 30};
    int m_credit = 0;
    int m_disp   = -1;
    int m_chg[$];
    bit m_rej = 1'b0;
    bit m_ins = 1'b0;
    int ms[4] = '{0, 0, 0, 0};
    bit taken;
    int v;

    function automatic int cv(input logic [1:0] c);
        case (c)
            2'b01:   return 5;
            2'b10:   return 10;
            2'b11:   return 25;
            default: return 0;
        endcase
    endfunction

    task automatic plan_change();
        int rem = m_credit;
        m_chg.delete();
        while (rem > 0) begin
            if (rem >= 25) begin m_chg.push_back(3); rem -= 25; end
            else if (rem >= 10) begin m_chg.push_back(2); rem -= 10; end
            else begin m_chg.push_back(1); rem -= 5; end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_credit = 0;
            m_disp   = -1;
            m_chg.delete();
            m_rej    = 1'b0;
            m_ins    = 1'b0;
            for (int i = 0; i < 4; i++) ms[i] = 0;
        end else begin
            m_rej = 1'b0;
            m_ins = 1'b0;
            if (m_disp >= 0) begin
                if (coin_valid) m_rej = 1'b1;
                if (hs.disp_ready) begin
                    if (ms[m_disp] < 65535) ms[m_disp]++;
                    m_disp = -1;
                    if (m_credit > 0) plan_change();
                end
            end else if (m_chg.size() > 0) begin
                if (coin_valid) m_rej = 1'b1;
                if (hs.chg_ready) begin
                    m_credit -= cv(2'(m_chg[0]));
                    void'(m_chg.pop_front());
                end
            end else begin
                taken = 1'b0;
                if (cancel && m_credit > 0) begin
                    plan_change();
                    taken = 1'b1;
                end else if (sel_valid) begin
                    if (m_credit >= mp[sel]) begin
                        m_credit -= mp[sel];
                        m_disp = int'(sel);
                        taken = 1'b1;
                    end else begin
                        m_ins = 1'b1;
                    end
                end
                if (coin_valid) begin
                    v = cv(coin);
                    if (taken || v == 0 || m_credit + v > 100) m_rej = 1'b1;
                    else m_credit += v;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("credit", 32'(credit), m_credit);
            check("disp_valid", 32'(hs.disp_valid), 32'(m_disp >= 0));
            if (m_disp >= 0) check("disp_id", 32'(hs.disp_id), m_disp);
            check("chg_valid", 32'(hs.chg_valid), 32'(m_chg.size() > 0));
            if (m_chg.size() > 0) check("chg_coin", 32'(hs.chg_coin), m_chg[0]);
            check("reject", 32'(reject), 32'(m_rej));
            check("insuf", 32'(insuf), 32'(m_ins));
            check("busy", 32'(busy), 32'(m_disp >= 0 || m_chg.size() > 0));
`ifdef VEND_SALES_CNT_EN
            for (int i = 0; i < 4; i++) check("sales_cnt", 32'(sales_cnt[i*16 +: 16]), ms[i]);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin = c;
        tick();
        coin_valid = 1'b0;
        coin = 2'b00;
    endtask

    task automatic select(input logic [1:0] s);
        sel_valid = 1'b1;
        sel = s;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(busy), 0);
    endtask

    initial begin
        int cnt;
        hs.disp_ready = 1'b1;
        hs.chg_ready  = 1'b1;
        rst = 1'b1;
        tick();
        mon_on = 1'b1;
        tick();
        check("rst_credit", 32'(credit), 0);
        check("rst_disp_id", 32'(hs.disp_id), 0);
        check("rst_chg_coin", 32'(hs.chg_coin), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // 10+10+10, buy product 3 (30): exact payment, no change
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
        check("a_credit30", 32'(credit), 30);
        select(2'd3);
        check("a_disp_valid", 32'(hs.disp_valid), 1);
        check("a_disp_id", 32'(hs.disp_id), 3);
        check("a_credit0", 32'(credit), 0);
        tick();
        check("a_idle", 32'(busy), 0);
        check("a_no_chg", 32'(hs.chg_valid), 0);

        // 25+25, buy product 0 (50) with disp_ready held off 3 cycles
        put_coin(2'b11); put_coin(2'b11);
        hs.disp_ready = 1'b0;
        select(2'd0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (hs.disp_valid) cnt++;
            if (i == 0) begin coin_valid = 1'b1; coin = 2'b11; end
            tick();
            coin_valid = 1'b0;
            if (i == 0) check("b_reject_in_disp", 32'(reject), 1);
        end
        hs.disp_ready = 1'b1;
        if (hs.disp_valid) cnt++;
        tick();
        check("b_disp_cycles", cnt, 4);
        check("b_disp_done", 32'(hs.disp_valid), 0);
        check("b_credit0", 32'(credit), 0);
        check("b_no_chg", 32'(hs.chg_valid), 0);

        // 75 in, buy product 2 (35): change 25, 10, 5
        put_coin(2'b11); put_coin(2'b11); put_coin(2'b11);
        select(2'd2);
        check("c_credit40", 32'(credit), 40);
        tick();
        check("c_chg1", 32'(hs.chg_coin), 3);
        tick();
        check("c_chg2", 32'(hs.chg_coin), 2);
        check("c_credit15", 32'(credit), 15);
        tick();
        check("c_chg3", 32'(hs.chg_coin), 1);
        tick();
        check("c_credit0", 32'(credit), 0);
        check("c_done", 32'(hs.chg_valid), 0);
        check("c_idle", 32'(busy), 0);

        // Credit ceiling and invalid coins
        put_coin(2'b11); put_coin(2'b11); put_coin(2'b11); put_coin(2'b10); put_coin(2'b01);
        check("d_credit90", 32'(credit), 90);
        put_coin(2'b11);
        check("d_reject_over", 32'(reject), 1);
        check("d_credit_keep", 32'(credit), 90);
        put_coin(2'b10);
        check("d_at_max", 32'(credit), 100);
        put_coin(2'b00);
        check("d_reject_00", 32'(reject), 1);
        put_coin(2'b01);
        check("d_reject_105", 32'(reject), 1);
        do_cancel();
        wait_idle();
        check("d_refunded", 32'(credit), 0);
        put_coin(2'b10); put_coin(2'b10);
        select(2'd1);
        check("d_insuf", 32'(insuf), 1);
        check("d_credit20", 32'(credit), 20);
        tick();
        check("d_insuf_pulse", 32'(insuf), 0);
        do_cancel();
        wait_idle();
        // Coin alongside a successful selection is refused
        put_coin(2'b11); put_coin(2'b11);
        sel_valid = 1'b1; sel = 2'd1; coin_valid = 1'b1; coin = 2'b10;
        tick();
        sel_valid = 1'b0; coin_valid = 1'b0;
        check("d_sel_coin_rej", 32'(reject), 1);
        check("d_sel_credit10", 32'(credit), 10);
        wait_idle();

        // Coin together with cancel, then reset while paying change
        put_coin(2'b11);
        cancel = 1'b1; coin_valid = 1'b1; coin = 2'b11;
        tick();
        cancel = 1'b0; coin_valid = 1'b0;
        check("e_reject", 32'(reject), 1);
        check("e_chg25", 32'(hs.chg_coin), 3);
        check("e_credit25", 32'(credit), 25);
        tick();
        check("e_credit0", 32'(credit), 0);
        put_coin(2'b11); put_coin(2'b11);
        hs.chg_ready = 1'b0;
        do_cancel();
        tick();
        check("e_chg_held", 32'(hs.chg_valid), 1);
        rst = 1'b1;
        tick();
        check("e_rst_credit", 32'(credit), 0);
        check("e_rst_chg", 32'(hs.chg_valid), 0);
        rst = 1'b0;
        hs.chg_ready = 1'b1;
        tick();
        check("e_after_rst", 32'(hs.chg_valid), 0);

`ifdef VEND_SALES_CNT_EN
        for (int k = 0; k < 2; k++) begin
            put_coin(2'b11); put_coin(2'b10); put_coin(2'b01);
            select(2'd1);
            wait_idle();
        end
        check("f_sales1", 32'(sales_cnt[31:16]), 2);
        check("f_sales0", 32'(sales_cnt[15:0]), 0);
        check("f_sales2", 32'(sales_cnt[47:32]), 0);
        check("f_sales3", 32'(sales_cnt[63:48]), 0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
